seq_gen: RTL
============

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The parameters SHALL be as follows, one per line: name, default, meaning.
  WIDTH, 8, payload bits per frame (>=2)
  GAP_LEN, 2, idle cycles between repeated frames (>=1)
REQ-002 The ports SHALL be as follows, one per line: name, direction, width, meaning.
  clk      input   1      clock, all state on rising edge
  rst_n    input   1      reset, asynchronous, active-low
  start    input   1      request a transmission; sampled only in IDLE
  data     input   WIDTH  payload, captured on the accept edge
  reps     input   4      frame repeat count, captured on the accept edge; 0 treated as 1
  dout     output  1      serial bit stream
  dvalid   output  1      dout carries a frame bit this cycle
  busy     output  1      transmission in progress
  done     output  1      one-cycle completion pulse

Function
REQ-003 The block SHALL be a Moore FSM with states IDLE, PRE, DATA and GAP; all outputs SHALL be decoded from registered state only.
REQ-004 Accept edge: a rising edge with state=IDLE and start=1 SHALL capture data into the shift register and max(reps,1) into the remaining-frame counter.
REQ-005 From IDLE, the accept edge SHALL move the FSM to PRE if the preamble is compiled in, else to DATA; the first bit SHALL appear on dout in the cycle after the accept edge.
REQ-006 PRE SHALL last 4 cycles emitting 1,0,1,0 in order with dvalid=1, then go to DATA.
REQ-007 DATA SHALL last WIDTH cycles emitting data MSB first, one bit per cycle, with dvalid=1.
REQ-008 After the last DATA bit, the FSM SHALL decrement the frame counter; if frames remain it SHALL go to GAP, else to IDLE.
REQ-009 GAP SHALL last GAP_LEN cycles with dout=0 and dvalid=0, then go to PRE or DATA per REQ-005, resending the same captured payload.
REQ-010 busy SHALL be 1 in PRE, DATA and GAP, and 0 in IDLE.
REQ-011 done SHALL be 1 for exactly the first IDLE cycle after the final frame, and 0 otherwise.
REQ-012 In IDLE, PRE-less GAP and any non-frame cycle, dout SHALL be 0.
REQ-013 start while busy=1 SHALL be ignored, and data/reps changes during busy SHALL NOT alter the frame in flight.
REQ-014 start=1 in the done cycle SHALL be accepted, so back-to-back transmissions have zero idle cycles beyond the done cycle.
REQ-015 Bit/gap counters SHALL be sized ceil(log2) of their maximum values and SHALL NOT wrap within a frame.

Reset
REQ-016 rst_n=0 SHALL immediately force state=IDLE, dout=0, dvalid=0, busy=0 and done=0, and clear the shift register and all counters.
REQ-017 A reset mid-frame SHALL abort the transmission with no done pulse; the first accept after release SHALL start a clean frame.

Configuration
REQ-018 With SEQ_GEN_PREAMBLE_EN defined, every frame SHALL be the 4-bit sync preamble 1010 followed by the payload (frame length 4+WIDTH).
REQ-019 Without SEQ_GEN_PREAMBLE_EN, the PRE state and its counter SHALL be absent and frames SHALL be the payload only (length WIDTH).

Verification
REQ-020 The bench SHALL cover the following directed scenarios.
  1) PREAMBLE_EN on, WIDTH=8, data=8'hA5, reps=1, start pulse at edge 0 -> dvalid high in cycles 1-12; dout=1,0,1,0,1,0,1,0,0,1,0,1; busy in cycles 1-12; done in cycle 13 only.
  2) Same as scenario 1 with reps=3, GAP_LEN=2 -> three identical frames separated by 2 cycles of dout=0/dvalid=0; busy continuous for 40 cycles; single done pulse.
  3) reps=0 -> identical to reps=1 (12 valid bits, one done pulse).
  4) start held at 1 throughout, data changed to 8'hFF mid-frame -> first frame still A5; new frame accepted in the done cycle carrying FF; no extra idle cycles.
  5) rst_n low at cycle 7 of a frame -> all outputs 0 immediately, no done pulse; after release, start with data=8'h3C -> correct full frame.
  6) PREAMBLE_EN off, data=8'hC3, reps=1 -> 8 valid bits 1,1,0,0,0,0,1,1 in cycles 1-8; done in cycle 9.

Source files
------------

// File: rtl/seq_gen_if.sv
// Request/stream bundle for seq_gen: request fields in, serial stream and status out.
// dbg_state mirrors the generator FSM state for checkers and debug.
interface seq_gen_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [3:0]       reps;
  logic             dout;
  logic             dvalid;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  // Handshake: a request is taken on any rising edge where start=1 and busy=0
  // (IDLE, including the done cycle); start while busy=1 is dropped, never queued.
  // dvalid=1 marks each cycle in which dout carries a frame bit.
  modport master (
    output start, data, reps,
    input  dout, dvalid, busy, done, dbg_state
  );

  modport slave (
    input  start, data, reps,
    output dout, dvalid, busy, done, dbg_state
  );
endinterface

// File: rtl/seq_gen.sv
// seq_gen: Moore serial frame generator, sends a captured payload MSB first, 1..15 times.
// Define SEQ_GEN_PREAMBLE_EN to prefix every frame with the 4-bit sync pattern 1010.
module seq_gen #(
  parameter int WIDTH   = 8,
  parameter int GAP_LEN = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  seq_gen_if.slave bus
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

`ifdef SEQ_GEN_PREAMBLE_EN
  localparam state_t FRAME_START = PRE;
`else
  localparam state_t FRAME_START = DATA;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shift_q;
  logic [3:0]       frames_q;
  logic [BIT_W-1:0] bit_q;
  logic [GAP_W-1:0] gap_q;
  logic             done_q;

  logic             accept;
  logic             last_bit;
  logic             last_frame;
  logic             gap_end;

`ifdef SEQ_GEN_PREAMBLE_EN
  logic [1:0]       pre_q;
  logic             pre_end;
`endif

  always_comb begin
    accept     = (state_q == IDLE) && bus.start;
    last_bit   = (state_q == DATA) && (bit_q == BIT_LAST);
    last_frame = (frames_q == 4'd1);
    gap_end    = (state_q == GAP) && (gap_q == GAP_LAST);
`ifdef SEQ_GEN_PREAMBLE_EN
    pre_end    = (state_q == PRE) && (pre_q == 2'd3);
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = FRAME_START;
`ifdef SEQ_GEN_PREAMBLE_EN
      PRE:  if (pre_end) state_d = DATA;
`endif
      DATA: if (last_bit) state_d = last_frame ? IDLE : GAP;
      GAP:  if (gap_end) state_d = FRAME_START;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The payload register rotates rather than shifts, so after WIDTH bits it
  // holds the original payload again, ready for the next repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      frames_q <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= last_bit && last_frame;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q  <= bus.data;
            frames_q <= (bus.reps == 4'd0) ? 4'd1 : bus.reps;
            bit_q    <= '0;
            gap_q    <= '0;
          end
        end
        DATA: begin
          shift_q <= {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
          if (last_bit) begin
            bit_q    <= '0;
            frames_q <= frames_q - 4'd1;
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_end) gap_q <= '0;
          else         gap_q <= gap_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_GEN_PREAMBLE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (state_q == PRE) begin
      pre_q <= pre_end ? 2'd0 : pre_q + 2'd1;
    end
  end
`endif

  // Outputs decode registered state only; PRE emits 1,0,1,0 from the counter LSB.
  always_comb begin
    bus.dout   = 1'b0;
    bus.dvalid = 1'b0;
    bus.busy   = (state_q != IDLE);
    bus.done   = done_q && (state_q == IDLE);
    unique case (state_q)
`ifdef SEQ_GEN_PREAMBLE_EN
      PRE: begin
        bus.dout   = ~pre_q[0];
        bus.dvalid = 1'b1;
      end
`endif
      DATA: begin
        bus.dout   = shift_q[WIDTH-1];
        bus.dvalid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.dbg_state = state_q;

endmodule
